dco_sar_cal: RTL and testbench
==============================

DCO_SAR_CAL -- requirements
Module: dco_sar_cal

Interface
REQ-001 Parameter DCODE_W, default 13, SHALL set the DCO control code width.
REQ-002 Parameter CNT_W, default 16, SHALL set the pulse-counter and target width.
REQ-003 Parameter WIN_CYC, default 1024, SHALL set the measurement window length in clk cycles.
REQ-004 Parameter SETTLE_CYC, default 16, SHALL set the idle cycles after each code change before measuring.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle calibration request.
REQ-008 target_cnt  input  CNT_W  desired DCO pulse count per window; sampled at start.
REQ-009 dco_pulse  input  1  one-cycle pulse per DCO rising edge, already synchronized into clk domain.
REQ-010 dcode  output  DCODE_W  control code driven to the DCO.
REQ-011 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-012 done  output  1  one-cycle pulse: calibration complete, dcode final.
REQ-013 meas_cnt  output  CNT_W  count from the most recent completed window.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, MEASURE, DECIDE, DONE.
REQ-015 In IDLE, start=1 SHALL latch target_cnt, set bit index to DCODE_W-1, load dcode to only the MSB set, and enter SETTLE.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles; dco_pulse is ignored there; then MEASURE.
REQ-018 MEASURE SHALL last exactly WIN_CYC cycles, counting dco_pulse sampled high in each of those cycles; counter saturates at 2^CNT_W-1.
REQ-019 DECIDE SHALL last one cycle: copy the count to meas_cnt; if count > latched target, clear the current trial bit; else keep it (equal keeps).
REQ-020 In DECIDE, if bit index > 0, decrement the index, set the new trial bit in dcode, and go to SETTLE; else go to DONE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 dcode SHALL hold its final value in IDLE until the next accepted start.
REQ-023 Start-to-DONE latency SHALL be exactly 1 + DCODE_W*(SETTLE_CYC+WIN_CYC+1) cycles.
REQ-024 For a monotonic non-decreasing code-to-frequency DCO, the result SHALL be the largest code whose window count <= target.

Reset
REQ-025 rst=1 at any clock edge, including mid-calibration, SHALL force IDLE, dcode=0, busy=0, done=0, meas_cnt=0, counters and index cleared.
REQ-026 rst SHALL take priority over start in the same cycle.

Structure
REQ-027 Package dco_ctrl_pkg SHALL hold the state enum and default width/window constants.
REQ-028 The window pulse counter (clear, enable, saturate) SHALL be a sub-module dco_win_cnt.

Verification (WIN_CYC=512, SETTLE_CYC=2; bench DCO model yields window count = dcode/16, floor)
REQ-029 target_cnt=100, start -> done after 1+13*515 cycles, dcode=1615, meas_cnt consistent with last trial.
REQ-030 target_cnt=0 -> dcode=15; target_cnt=600 -> dcode=8191.
REQ-031 start pulsed again while busy -> ignored, result and latency unchanged.
REQ-032 rst asserted during MEASURE of bit 6 -> next cycle IDLE, dcode=0, busy=0, no done.
REQ-033 dco_pulse held high continuously with CNT_W=8, target 255 -> count saturates at 255, no wrap, all bits kept, dcode=8191.
REQ-034 rst and start in same cycle -> remain IDLE; later start alone -> normal calibration.

Source files
------------

// File: rtl/dco_ctrl_pkg.sv
// Shared types and default sizing for the DCO successive-approximation calibrator.
package dco_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_DONE    = 3'd4
    } cal_state_t;

    localparam int DEF_DCODE_W    = 13;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_WIN_CYC    = 1024;
    localparam int DEF_SETTLE_CYC = 16;

    // Width of a down/up timer able to hold values 0..max_val.
    function automatic int tmr_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dco_win_cnt.sv
// Saturating DCO pulse counter for one measurement window.
module dco_win_cnt
    import dco_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             pulse,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Pulse accumulator: clear wins over enable, holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && pulse && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/dco_sar_cal.sv
// Binary-search (SAR) calibration of a DCO control code against a target
// pulse count per measurement window.
module dco_sar_cal
    import dco_ctrl_pkg::*;
#(
    parameter int DCODE_W    = DEF_DCODE_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_CYC    = DEF_WIN_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   target_cnt,
    input  logic               dco_pulse,
    output logic [DCODE_W-1:0] dcode,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   meas_cnt
);

    localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int TMR_W   = tmr_width(TMR_MAX);
    localparam int IDX_W   = tmr_width(DCODE_W - 1);

    cal_state_t         state_r, state_next_s;
    logic [TMR_W-1:0]   tmr_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   target_r;
    logic [DCODE_W-1:0] dcode_r;
    logic [CNT_W-1:0]   meas_cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               cnt_clr_s;
    logic               cnt_en_s;
    logic [CNT_W-1:0]   win_cnt_s;
    logic [DCODE_W-1:0] bit_mask_s;
    logic [DCODE_W-1:0] dcode_dec_s;

    dco_win_cnt #(.CNT_W(CNT_W)) u_win_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .pulse (dco_pulse),
        .count (win_cnt_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_next_s = state_r;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (start) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_clr_s = 1'b1;
                if (tmr_r == TMR_W'(SETTLE_CYC - 1)) begin
                    state_next_s = ST_MEASURE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_MEASURE: begin
                cnt_en_s = 1'b1;
                if (tmr_r == TMR_W'(WIN_CYC - 1)) begin
                    state_next_s = ST_DECIDE;
                end else begin
                    state_next_s = ST_MEASURE;
                end
            end
            ST_DECIDE: begin
                if (idx_r != {IDX_W{1'b0}}) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Trial bit is dropped only when the DCO ran too fast; the next lower bit
    // becomes the new trial (mask shifts to zero after bit 0).
    always_comb begin
        bit_mask_s  = {{(DCODE_W-1){1'b0}}, 1'b1} << idx_r;
        dcode_dec_s = ((win_cnt_s > target_r) ? (dcode_r & ~bit_mask_s) : dcode_r)
                      | (bit_mask_s >> 1);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_r      <= {TMR_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            target_r   <= {CNT_W{1'b0}};
            dcode_r    <= {DCODE_W{1'b0}};
            meas_cnt_r <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
            if (((state_r == ST_SETTLE) || (state_r == ST_MEASURE)) && (state_next_s == state_r)) begin
                tmr_r <= tmr_r + TMR_W'(1);
            end else begin
                tmr_r <= {TMR_W{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        target_r <= target_cnt;
                        idx_r    <= IDX_W'(DCODE_W - 1);
                        dcode_r  <= {1'b1, {(DCODE_W-1){1'b0}}};
                    end else begin
                        target_r <= target_r;
                    end
                end
                ST_DECIDE: begin
                    meas_cnt_r <= win_cnt_s;
                    dcode_r    <= dcode_dec_s;
                    if (idx_r != {IDX_W{1'b0}}) begin
                        idx_r <= idx_r - IDX_W'(1);
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    dcode_r <= dcode_r;
                end
            endcase
        end
    end

    assign dcode    = dcode_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign meas_cnt = meas_cnt_r;

endmodule

// File: tb/tb_dco_sar_cal.sv
// Directed bench for dco_sar_cal: DCO model gives window count = dcode/16.
module tb_dco_sar_cal;

    localparam int DW  = 13;
    localparam int CW  = 16;
    localparam int WIN = 512;
    localparam int SET = 2;
    localparam int LAT = 1 + DW * (SET + WIN + 1);

    logic          clk = 1'b0;
    logic          rst, start, pulse;
    logic [CW-1:0] target;
    logic [DW-1:0] dcode;
    logic          busy, done;
    logic [CW-1:0] meas;

    logic          start2, pulse2;
    logic [7:0]    target2;
    logic [DW-1:0] dcode2;
    logic          busy2, done2;
    logic [7:0]    meas2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dco_sar_cal #(.DCODE_W(DW), .CNT_W(CW), .WIN_CYC(WIN), .SETTLE_CYC(SET)) dut (
        .clk(clk), .rst(rst), .start(start), .target_cnt(target), .dco_pulse(pulse),
        .dcode(dcode), .busy(busy), .done(done), .meas_cnt(meas)
    );

    dco_sar_cal #(.DCODE_W(DW), .CNT_W(8), .WIN_CYC(WIN), .SETTLE_CYC(SET)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .target_cnt(target2), .dco_pulse(pulse2),
        .dcode(dcode2), .busy(busy2), .done(done2), .meas_cnt(meas2)
    );

    // DCO model: phase accumulator emits exactly dcode/16 pulses in any 512 cycles.
    logic [8:0] acc = 9'd0;
    logic [9:0] sum;
    assign sum   = {1'b0, acc} + {1'b0, dcode[12:4]};
    assign pulse = sum[9];
    always @(posedge clk) acc <= sum[8:0];

    typedef struct {
        int tgt;
        int exp_dcode;
        int exp_meas;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Runs one calibration on the main DUT; called at a negedge, returns at a negedge.
    task automatic run_cal(input int tgt, input int glitch_at, output int lat);
        target = CW'(tgt);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        check("busy_after_start", int'(busy), 1);
        while (!done && lat <= LAT + 50) begin
            start = (lat == glitch_at);
            if (lat == glitch_at) target = CW'(0);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_seen", int'(done), 1);
        check("busy_in_done", int'(busy), 1);
    endtask

    initial begin
        int lat;
        int seen;
        vecs[0] = '{tgt: 100, exp_dcode: 1615, exp_meas: 100};
        vecs[1] = '{tgt: 0,   exp_dcode: 15,   exp_meas: 0};
        vecs[2] = '{tgt: 600, exp_dcode: 8191, exp_meas: 511};
        vecs[3] = '{tgt: 50,  exp_dcode: 815,  exp_meas: 50};
        vecs[4] = '{tgt: 511, exp_dcode: 8191, exp_meas: 511};

        rst = 1'b1; start = 1'b0; target = '0;
        start2 = 1'b0; target2 = 8'd0; pulse2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dcode", int'(dcode), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_meas", int'(meas), 0);
        check("rst_sat_dcode", int'(dcode2), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_cal(vecs[i].tgt, -1, lat);
            check("latency", lat, LAT);
            check("dcode", int'(dcode), vecs[i].exp_dcode);
            check("meas_cnt", int'(meas), vecs[i].exp_meas);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
            check("busy_cleared", int'(busy), 0);
            repeat (4) @(negedge clk);
            check("dcode_hold", int'(dcode), vecs[i].exp_dcode);
        end

        // Start pulsed (with a different target) mid-calibration must be ignored.
        run_cal(100, 200, lat);
        check("glitch_latency", lat, LAT);
        check("glitch_dcode", int'(dcode), 1615);
        @(negedge clk);

        // Reset during MEASURE of bit 6 (cycles 3093..3604 after start).
        target = CW'(100);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (3199) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_dcode", int'(dcode), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_meas", int'(meas), 0);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("midrst_no_done", seen, 0);

        // Reset and start together: reset wins.
        rst = 1'b1; start = 1'b1; target = CW'(100);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rststart_busy", int'(busy), 0);
        check("rststart_dcode", int'(dcode), 0);
        repeat (5) @(negedge clk);
        check("rststart_idle", int'(busy), 0);
        run_cal(100, -1, lat);
        check("after_rst_latency", lat, LAT);
        check("after_rst_dcode", int'(dcode), 1615);
        @(negedge clk);

        // Continuous pulses with an 8-bit counter: saturate at 255, keep every bit.
        pulse2  = 1'b1;
        target2 = 8'd255;
        start2  = 1'b1;
        @(negedge clk);
        start2  = 1'b0;
        lat = 1;
        while (!done2 && lat <= LAT + 50) begin
            @(negedge clk);
            lat++;
        end
        check("sat_latency", lat, LAT);
        check("sat_dcode", int'(dcode2), 8191);
        check("sat_meas", int'(meas2), 255);
        pulse2 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
